dmem_arbiter: RTL and testbench

Two-port, multi-cycle access controller for the single data memory (`datamem`) used by the MEM stage. It shares the memory between the pipeline's MEM-stage requester and a debug/loader requester, using round-robin arbitration. It sequences each access over a fixed memory latency and stalls the pipeline until the CPU's access completes. It sits between the MEM-stage datapath and `datamem`, and replaces the direct MEM→memory connection.

---
 rtl/dmem_arb_pkg.sv | 9 +
 rtl/dmem_rr_pick.sv | 20 ++
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and port identifiers for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin selector: a tie goes to the port that was not granted last.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_port,
  output logic       grant_valid,
  output logic       grant_port
);

  always_comb begin
    grant_valid = |req;
    if (&req) begin
      grant_port = ~last_port;
    end else begin
      grant_port = req[PORT_DBG] ? PORT_DBG : PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares datamem between the MEM-stage and debug/loader ports; each access occupies
// LATENCY busy cycles followed by a one-cycle ack.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned AW      = 64,
  parameter int unsigned DW      = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [3:0]    cpu_xfer_size,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic [3:0]    dbg_xfer_size,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_address,
  output logic          mem_write_enable,
  output logic          mem_read_enable,
  output logic [DW-1:0] mem_write_data,
  output logic [3:0]    mem_xfer_size,
  input  logic [DW-1:0] mem_read_data,
  output logic          owner
);

  localparam int unsigned    CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(LATENCY - 1);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_size;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dbg_rdata;

  logic          w_grant_valid;
  logic          w_grant_port;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic [3:0]    w_sel_size;

  dmem_rr_pick u_pick (
    .req         ({dbg_req, cpu_req}),
    .last_port   (r_last),
    .grant_valid (w_grant_valid),
    .grant_port  (w_grant_port)
  );

  always_comb begin
    w_sel_we    = (w_grant_port == PORT_DBG) ? dbg_we        : cpu_we;
    w_sel_addr  = (w_grant_port == PORT_DBG) ? dbg_addr      : cpu_addr;
    w_sel_wdata = (w_grant_port == PORT_DBG) ? dbg_wdata     : cpu_wdata;
    w_sel_size  = (w_grant_port == PORT_DBG) ? dbg_xfer_size : cpu_xfer_size;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_grant_valid) w_state_nxt = ARB_BUSY;
      ARB_BUSY: if (r_cnt == '0)   w_state_nxt = ARB_DONE;
      ARB_DONE: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  // Enables are decoded from state so a reset edge drops them immediately.
  always_comb begin
    mem_read_enable  = (r_state == ARB_BUSY) && !r_we;
    mem_write_enable = (r_state == ARB_BUSY) && r_we && (r_cnt == '0);
    cpu_ack          = (r_state == ARB_DONE) && (r_owner == PORT_CPU);
    dbg_ack          = (r_state == ARB_DONE) && (r_owner == PORT_DBG);
    cpu_stall        = cpu_req && !cpu_ack;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last      <= PORT_DBG;
      r_owner     <= PORT_CPU;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_size      <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_valid) begin
            r_owner <= w_grant_port;
            r_last  <= w_grant_port;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_size  <= w_sel_size;
            r_cnt   <= CNT_LOAD;
          end
        end
        ARB_BUSY: begin
          if (r_cnt == '0) begin
            if (!r_we) begin
              if (r_owner == PORT_DBG) r_dbg_rdata <= mem_read_data;
              else                     r_cpu_rdata <= mem_read_data;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_address    = r_addr;
  assign mem_write_data = r_wdata;
  assign mem_xfer_size  = r_size;
  assign cpu_rdata      = r_cpu_rdata;
  assign dbg_rdata      = r_dbg_rdata;
  assign owner          = r_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model and an expected-result queue.
module tb_dmem_arbiter;

  localparam int LAT = 3;

  typedef struct {
    logic        port;
    logic        load;
    logic [63:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_init;
  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_xfer_size;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [63:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [3:0]  dbg_xfer_size;
  logic [63:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable, owner;
  logic [3:0]  mem_xfer_size;

  logic        c1_req, c1_we, c1_ack, c1_stall, d1_req, d1_we, d1_ack, m1_we, m1_re, owner1;
  logic [63:0] c1_addr, c1_wdata, c1_rdata, d1_addr, d1_wdata, d1_rdata;
  logic [63:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  c1_size, d1_size, m1_size;

  logic [7:0]  dm   [256];
  logic [7:0]  refm [256];
  exp_t        sb[$];
  int          ntests = 0;
  int          nfail  = 0;

  dmem_arbiter #(.LATENCY(LAT), .AW(64), .DW(64)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_xfer_size(cpu_xfer_size), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_xfer_size(dbg_xfer_size), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_write_data(mem_write_data), .mem_xfer_size(mem_xfer_size), .mem_read_data(mem_read_data),
    .owner(owner)
  );

  dmem_arbiter #(.LATENCY(1), .AW(64), .DW(64)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_xfer_size(c1_size), .cpu_ack(c1_ack), .cpu_rdata(c1_rdata), .cpu_stall(c1_stall),
    .dbg_req(d1_req), .dbg_we(d1_we), .dbg_addr(d1_addr), .dbg_wdata(d1_wdata),
    .dbg_xfer_size(d1_size), .dbg_ack(d1_ack), .dbg_rdata(d1_rdata),
    .mem_address(m1_addr), .mem_write_enable(m1_we), .mem_read_enable(m1_re),
    .mem_write_data(m1_wdata), .mem_xfer_size(m1_size), .mem_read_data(m1_rdata),
    .owner(owner1)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // Memory model: writes only through the full-latency DUT, reads by both DUTs.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) dm[i] <= pat(i);
    end else if (mem_write_enable) begin
      for (int i = 0; i < 8; i++)
        if (i < int'(mem_xfer_size)) dm[mem_address[7:0] + 8'(i)] <= mem_write_data[8*i +: 8];
    end
  end

  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 8; i++)
      if (i < int'(mem_xfer_size)) mem_read_data[8*i +: 8] = dm[mem_address[7:0] + 8'(i)];
  end

  always_comb begin
    m1_rdata = '0;
    for (int i = 0; i < 8; i++)
      if (i < int'(m1_size)) m1_rdata[8*i +: 8] = dm[m1_addr[7:0] + 8'(i)];
  end

  function automatic logic [63:0] ref_read(input logic [63:0] a, input logic [3:0] sz);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++)
      if (i < int'(sz)) r[8*i +: 8] = refm[a[7:0] + 8'(i)];
    return r;
  endfunction

  task automatic ref_write(input logic [63:0] a, input logic [63:0] d, input logic [3:0] sz);
    for (int i = 0; i < 8; i++)
      if (i < int'(sz)) refm[a[7:0] + 8'(i)] = d[8*i +: 8];
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop_check(input string tag, input logic port, input logic [63:0] rdata);
    exp_t e;
    chk1({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk1({tag, "_ack_port"}, port, e.port);
      if (e.load) chk64({tag, "_rdata"}, rdata, e.rdata);
    end
  endtask

  task automatic drive(input logic port, input logic req, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [3:0] sz);
    if (port) begin
      dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_xfer_size = sz;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_xfer_size = sz;
    end
  endtask

  task automatic access(input string tag, input logic port, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [3:0] sz);
    exp_t e;
    logic ack_now;
    e.port = port; e.load = !we;
    e.rdata = we ? 64'h0 : ref_read(addr, sz);
    if (we) ref_write(addr, wdata, sz);
    sb.push_back(e);
    @(posedge clk); #1;
    drive(port, 1'b1, we, addr, wdata, sz);
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (port == 1'b0) chk1({tag, "_stall"}, cpu_stall, k <= LAT);
      chk1({tag, "_wen"}, mem_write_enable, we && (k == LAT));
      chk1({tag, "_ren"}, mem_read_enable, !we && (k >= 1) && (k <= LAT));
      chk1({tag, "_cpu_ack"}, cpu_ack, (port == 1'b0) && (k == LAT + 1));
      chk1({tag, "_dbg_ack"}, dbg_ack, (port == 1'b1) && (k == LAT + 1));
      if (k == 1) chk64({tag, "_addr"}, mem_address, addr);
      if (k == LAT && we) chk64({tag, "_wdata"}, mem_write_data, wdata);
      ack_now = port ? dbg_ack : cpu_ack;
      if (ack_now) sb_pop_check(tag, port, port ? dbg_rdata : cpu_rdata);
    end
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic [63:0] d_before;
    logic        ack_c, ack_d;
    exp_t        e;

    for (int i = 0; i < 256; i++) refm[i] = pat(i);
    reset = 1'b1; mem_init = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0; c1_size = '0;
    d1_req = 1'b0; d1_we = 1'b0; d1_addr = '0; d1_wdata = '0; d1_size = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_cpu_ack", cpu_ack, 1'b0);
    chk1("rst_dbg_ack", dbg_ack, 1'b0);
    chk1("rst_wen", mem_write_enable, 1'b0);
    chk1("rst_ren", mem_read_enable, 1'b0);
    chk64("rst_addr", mem_address, 64'h0);
    chk64("rst_cpu_rdata", cpu_rdata, 64'h0);
    chk1("rst_owner", owner, 1'b0);

    // Both ports request in the first cycle after reset and hold for four accesses.
    for (int n = 0; n < 4; n++) begin
      e.port = n[0]; e.load = 1'b1;
      e.rdata = n[0] ? ref_read(64'h40, 4'd8) : ref_read(64'd100, 4'd8);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_init = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 64'd100, '0, 4'd8);
    drive(1'b1, 1'b1, 1'b0, 64'h40, '0, 4'd8);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ack_c = (k % 5 == 4) && ((k / 5) % 2 == 0);
      ack_d = (k % 5 == 4) && ((k / 5) % 2 == 1);
      chk1("tie_cpu_ack", cpu_ack, ack_c);
      chk1("tie_dbg_ack", dbg_ack, ack_d);
      chk1("tie_stall", cpu_stall, !ack_c);
      if (k % 5 == 2) chk1("tie_owner", owner, 1'((k / 5) % 2));
      if (cpu_ack) sb_pop_check("tie", 1'b0, cpu_rdata);
      if (dbg_ack) sb_pop_check("tie", 1'b1, dbg_rdata);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);

    access("cpu_store", 1'b0, 1'b1, 64'd100, 64'd1024, 4'd8);
    d_before = dbg_rdata;
    access("cpu_load", 1'b0, 1'b0, 64'd100, '0, 4'd8);
    chk64("cpu_load_value", cpu_rdata, 64'd1024);
    chk64("dbg_rdata_kept", dbg_rdata, d_before);
    access("dbg_store", 1'b1, 1'b1, 64'd101, 64'd2, 4'd1);
    access("cpu_load_b", 1'b0, 1'b0, 64'd101, '0, 4'd1);
    chk64("cpu_byte_value", cpu_rdata, 64'd2);

    // Reset in cycle 2 of a CPU load: access abandoned, no ack.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 64'd100, '0, 4'd8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk1("midrst_ren_before", mem_read_enable, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk64("midrst_addr", mem_address, 64'h0);
    chk64("midrst_size", 64'(mem_xfer_size), 64'h0);
    chk1("midrst_ren", mem_read_enable, 1'b0);
    chk1("midrst_wen", mem_write_enable, 1'b0);
    chk64("midrst_cpu_rdata", cpu_rdata, 64'h0);
    chk64("midrst_dbg_rdata", dbg_rdata, 64'h0);
    chk1("midrst_owner", owner, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("midrst_no_ack", cpu_ack, 1'b0);
    end
    access("post_rst_load", 1'b0, 1'b0, 64'd100, '0, 4'd8);

    // LATENCY=1 build: one BUSY cycle, ack in cycle 2.
    e.port = 1'b0; e.load = 1'b1; e.rdata = ref_read(64'd100, 4'd8);
    sb.push_back(e);
    @(posedge clk); #1;
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 64'd100; c1_size = 4'd8;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      chk1("lat1_ren", m1_re, k == 1);
      chk1("lat1_ack", c1_ack, k == 2);
      chk1("lat1_stall", c1_stall, k < 2);
      if (c1_ack) sb_pop_check("lat1", 1'b0, c1_rdata);
    end
    @(posedge clk); #1;
    c1_req = 1'b0;

    chk64("sb_drained", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
